// File: rtl/pippo_pcgen.sv
// -----------------------------------------------------------------------------
// pippo_pcgen -- next-PC generator and fetch sequencer
//
// Holds the fetch PC. It issues one instruction-memory request at a time and
// applies redirects from the branch unit and from exception/return logic. It
// presents the fetched instruction and its address pair (cia/snia) to ID.
//
// Ports
//   clk_i                  clock
//   rst_ni                 asynchronous active-low reset
//   npc_branch_valid_i     branch redirect valid (EXE)
//   npc_branch_i   [31:0]  branch redirect target
//   flush_branch_i         kill the IF/ID contents
//   npc_except_valid_i     exception/return redirect; wins over branch, flushes
//   npc_except_i   [31:0]  exception/return target
//   stall_if_i             ID cannot accept; hold the IF output
//   imem_req_o             fetch request, held until imem_ack_i
//   imem_addr_o    [31:0]  fetch address, stable while imem_req_o=1
//   imem_ack_i             data/err valid this cycle; ends the request
//   imem_dat_i     [31:0]  fetched word
//   imem_err_i             bus error, qualified by imem_ack_i
//   if_valid_o             if_insn_o/if_cia_o/if_snia_o valid to ID
//   if_insn_o      [31:0]  instruction (nop when an error is reported)
//   if_cia_o       [31:0]  address of if_insn_o
//   if_snia_o      [31:0]  if_cia_o + 4 (mod 2^32)
//   if_err_o       [1:0]   00 none, 01 bus error, 10 misaligned target
//
// The IF output is a two-entry buffer: the visible output register plus a
// one-entry skid register. The skid catches the single fetch that may still
// complete after ID stalls. A new request is only launched while the buffer
// has room for its result, so no fetched word is ever dropped for lack of space.
// -----------------------------------------------------------------------------
module pippo_pcgen #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        npc_branch_valid_i,
  input  logic [31:0] npc_branch_i,
  input  logic        flush_branch_i,
  input  logic        npc_except_valid_i,
  input  logic [31:0] npc_except_i,
  input  logic        stall_if_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_dat_i,
  input  logic        imem_err_i,
  output logic        if_valid_o,
  output logic [31:0] if_insn_o,
  output logic [31:0] if_cia_o,
  output logic [31:0] if_snia_o,
  output logic [1:0]  if_err_o
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [1:0]  ERR_NONE  = 2'b00;
  localparam logic [1:0]  ERR_BUS   = 2'b01;
  localparam logic [1:0]  ERR_ALIGN = 2'b10;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  typedef struct packed {
    logic        v;
    logic [31:0] insn;
    logic [31:0] cia;
    logic [31:0] snia;
    logic [1:0]  err;
  } entry_t;

  // Build a valid IF entry; snia wraps modulo 2^32 like the PC itself.
  function automatic entry_t mk_entry(input logic [31:0] insn,
                                      input logic [31:0] cia,
                                      input logic [1:0]  err);
    entry_t e;
    e.v    = 1'b1;
    e.insn = insn;
    e.cia  = cia;
    e.snia = cia + 32'd4;
    e.err  = err;
    return e;
  endfunction

  localparam entry_t ENTRY_RST = '{v: 1'b0, insn: NOP, cia: 32'h0000_0000,
                                   snia: 32'h0000_0000, err: ERR_NONE};

  state_e      state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] tgt_q,   tgt_d;     // redirect target saved while draining
  logic        req_q,   req_d;
  logic [31:0] addr_q,  addr_d;
  entry_t      out_q,   out_d;     // visible IF output
  entry_t      skid_q,  skid_d;    // holds one fetch completed during a stall

  logic        redir_s;
  logic [31:0] redir_tgt_s;
  logic        flush_s;
  logic        hit_s;
  logic        consume_s;

  entry_t      base0_s, base1_s;   // buffer after consume/flush, before push
  logic [1:0]  base_cnt_s;

  logic        fpush_s;            // fetch result (data or bus error) to buffer
  entry_t      fentry_s;
  logic        want_s;             // try to start a fetch at lpc_s
  logic [31:0] lpc_s;
  logic        drain_s;
  logic        room_s;
  logic        lpush_s;            // misaligned-target report to buffer
  entry_t      lentry_s;
  logic        push_s;
  entry_t      push_e_s;

  assign redir_s     = npc_except_valid_i | npc_branch_valid_i;
  assign redir_tgt_s = npc_except_valid_i ? npc_except_i : npc_branch_i;
  assign flush_s     = flush_branch_i | npc_except_valid_i;
  // An ack only counts while a request is actually on the bus.
  assign hit_s       = req_q & imem_ack_i;
  assign consume_s   = out_q.v & ~stall_if_i;

  // Buffer contents after this cycle's hand-off to ID and any flush.
  always_comb begin
    base0_s = out_q;
    base1_s = skid_q;
    if (flush_s) begin
      base0_s.v = 1'b0;
      base1_s.v = 1'b0;
    end else if (consume_s) begin
      base0_s   = skid_q;
      base1_s   = skid_q;
      base1_s.v = 1'b0;
    end else begin
      base0_s = out_q;
      base1_s = skid_q;
    end
    base_cnt_s = {1'b0, base0_s.v} + {1'b0, base1_s.v};
  end

  // Next-state, PC and request decisions.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    req_d    = req_q;
    addr_d   = addr_q;
    fpush_s  = 1'b0;
    fentry_s = ENTRY_RST;
    want_s   = 1'b0;
    lpc_s    = pc_q;
    drain_s  = 1'b0;
    lpush_s  = 1'b0;
    lentry_s = ENTRY_RST;

    case (state_q)
      S_BOOT: begin
        want_s = 1'b1;
        lpc_s  = RESET_VEC;
      end
      S_FETCH, S_DRAIN: begin
        // A redirect with a request in flight cannot cancel it; remember the
        // latest target and wait for the ack.
        if (redir_s) begin
          tgt_d = redir_tgt_s;
        end else begin
          tgt_d = tgt_q;
        end
        drain_s = (state_q == S_DRAIN) | redir_s;
        if (hit_s) begin
          if (drain_s) begin
            want_s = 1'b1;
            lpc_s  = redir_s ? redir_tgt_s : tgt_q;
          end else if (imem_err_i) begin
            fpush_s  = 1'b1;
            fentry_s = mk_entry(NOP, pc_q, ERR_BUS);
            state_d  = S_HALT;
            req_d    = 1'b0;
          end else begin
            fpush_s  = 1'b1;
            fentry_s = mk_entry(imem_dat_i, pc_q, ERR_NONE);
            want_s   = 1'b1;
            lpc_s    = pc_q + 32'd4;
          end
        end else if (drain_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redir_s) begin
          want_s = 1'b1;
          lpc_s  = redir_tgt_s;
        end else begin
          want_s = 1'b1;
          lpc_s  = pc_q;
        end
      end
      S_HALT: begin
        // Parked after an error; only a redirect restarts fetching.
        if (redir_s) begin
          want_s = 1'b1;
          lpc_s  = redir_tgt_s;
        end else begin
          want_s = 1'b0;
        end
      end
      default: begin
        state_d = S_BOOT;
        req_d   = 1'b0;
      end
    endcase

    // Launch only when the result is sure to find a free buffer slot.
    room_s = (base_cnt_s + {1'b0, fpush_s & ~flush_s}) < 2'd2;

    if (want_s) begin
      pc_d = lpc_s;
      if (room_s) begin
        if (lpc_s[1:0] != 2'b00) begin
          lpush_s  = 1'b1;
          lentry_s = mk_entry(NOP, lpc_s, ERR_ALIGN);
          state_d  = S_HALT;
          req_d    = 1'b0;
        end else begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          addr_d  = lpc_s;
        end
      end else begin
        state_d = S_HOLD;
        req_d   = 1'b0;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Append the new entry (if any) behind whatever survives in the buffer.
  // A flush also kills a fetch result arriving in the same cycle.
  always_comb begin
    push_s   = (fpush_s & ~flush_s) | lpush_s;
    push_e_s = lpush_s ? lentry_s : fentry_s;
    out_d    = base0_s;
    skid_d   = base1_s;
    if (push_s) begin
      if (!base0_s.v) begin
        out_d = push_e_s;
      end else begin
        skid_d = push_e_s;
      end
    end else begin
      out_d  = base0_s;
      skid_d = base1_s;
    end
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      tgt_q   <= RESET_VEC;
      req_q   <= 1'b0;
      addr_q  <= RESET_VEC;
      out_q   <= ENTRY_RST;
      skid_q  <= ENTRY_RST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid_o  = out_q.v;
  assign if_insn_o   = out_q.insn;
  assign if_cia_o    = out_q.cia;
  assign if_snia_o   = out_q.snia;
  assign if_err_o    = out_q.err;

endmodule
